// File: rtl/s4ga_ff.sv
// Streaming K-LUT gate array: serial config segments build one LUT at a time into an addressable value array.
// Latency: a LUT result is visible on po one cycle after its commit edge (registered LUTs after the frame-end edge).
// Backpressure: none outward; si_valid low freezes all sequencing state, so the stream may stall on any cycle.
module s4ga_ff #(
  parameter int N     = 16,
  parameter int K     = 4,
  parameter int SI_W  = 4,
  parameter int N_IN  = 4,
  parameter int N_OUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SI_W-1:0]  si,
  input  logic             si_valid,
  input  logic [N_IN-1:0]  pi,
  output logic [N_OUT-1:0] po,
  output logic             frame_done
);

  localparam int IDX_W     = $clog2(N + N_IN);
  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
  localparam int MASK_BITS = 1 << K;
  localparam int MASK_SEGS = (MASK_BITS + SI_W - 1) / SI_W;
  localparam int MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int SH_W      = MAX_SEGS * SI_W;
  localparam int SRC_W     = 1 << IDX_W;
  localparam int NW        = (N > 1) ? $clog2(N) : 1;
  localparam int KW        = (K > 1) ? $clog2(K) : 1;
  localparam int SW        = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;

  typedef enum logic [1:0] {
    ST_REG,
    ST_IDX,
    ST_MASK
  } state_t;

  state_t           state, state_nxt;
  logic [NW-1:0]    n, n_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [SW-1:0]    seg, seg_nxt;
  logic [SH_W-1:0]  sh, sh_nxt;
  logic             reg_flag;
  logic [K-1:0]     ins;
  logic [N_IN-1:0]  pi_q;
  logic [N-1:0]     value, pending, reg_map;
  logic [N-1:0]     value_c, pending_c, reg_map_c;
  logic             idx_done, commit, last_lut;
  logic [IDX_W-1:0] idx_val;
  logic [SRC_W-1:0] src;
  logic             idx_bit;
  logic [MASK_BITS-1:0] mask_val;
  logic             lut_r;

  // Field assembly: segments arrive most-significant first, so the newest segment lands in the low bits.
  // Stale bits from earlier fields shift above the field width and are never looked at.
  assign sh_nxt   = (sh << SI_W) | SH_W'(si);
  assign idx_val  = sh_nxt[IDX_W-1:0];
  assign mask_val = sh_nxt[MASK_BITS-1:0];
  assign lut_r    = mask_val[ins];
  assign last_lut = (n == NW'(N - 1));
  assign po       = value[N_OUT-1:0];

  // Next-state sequencing: REG -> K index fields -> mask -> next LUT; held while si_valid is low
  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    k_nxt     = k;
    seg_nxt   = seg;
    idx_done  = 1'b0;
    commit    = 1'b0;
    if (si_valid) begin
      case (state)
        ST_REG: begin
          state_nxt = ST_IDX;
          k_nxt     = '0;
          seg_nxt   = '0;
        end
        ST_IDX: begin
          if (seg == SW'(IDX_SEGS - 1)) begin
            idx_done = 1'b1;
            seg_nxt  = '0;
            if (k == KW'(K - 1)) begin
              k_nxt     = '0;
              state_nxt = ST_MASK;
            end else begin
              k_nxt = k + 1'b1;
            end
          end else begin
            seg_nxt = seg + 1'b1;
          end
        end
        ST_MASK: begin
          if (seg == SW'(MASK_SEGS - 1)) begin
            commit    = 1'b1;
            seg_nxt   = '0;
            state_nxt = ST_REG;
            n_nxt     = last_lut ? '0 : n + 1'b1;
          end else begin
            seg_nxt = seg + 1'b1;
          end
        end
        default: state_nxt = ST_REG;
      endcase
    end
  end

  // FSM state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REG;
      n     <= '0;
      k     <= '0;
      seg   <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      k     <= k_nxt;
      seg   <= seg_nxt;
    end
  end

  // Segment shift register, advances only on accepted segments
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (si_valid) begin
      sh <= sh_nxt;
    end
  end

  // Unified index space: LUT values, then sampled inputs, then zeros for out-of-range indices
  always_comb begin
    src             = '0;
    src[N-1:0]      = value;
    src[N+N_IN-1:N] = pi_q;
    idx_bit         = src[idx_val];
  end

  // Registered flag, resolved LUT inputs, and the per-frame input sample taken at LUT 0's REG segment
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_flag <= 1'b0;
      ins      <= '0;
      pi_q     <= '0;
    end else begin
      if (si_valid && state == ST_REG) begin
        reg_flag <= si[0];
        if (n == '0) pi_q <= pi;
      end
      if (idx_done) ins[k] <= idx_bit;
    end
  end

  // Commit and frame-end update; the last LUT's own result is folded in before the registered copy-over
  always_comb begin
    value_c   = value;
    pending_c = pending;
    reg_map_c = reg_map;
    if (commit) begin
      reg_map_c[n] = reg_flag;
      if (reg_flag) pending_c[n] = lut_r;
      else          value_c[n]   = lut_r;
      if (last_lut) value_c = (value_c & ~reg_map_c) | (pending_c & reg_map_c);
    end
  end

  // LUT value, pending and registered-map storage
  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      pending <= '0;
      reg_map <= '0;
    end else begin
      value   <= value_c;
      pending <= pending_c;
      reg_map <= reg_map_c;
    end
  end

  // One-cycle pulse following the last LUT's commit edge
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= commit && last_lut;
  end

endmodule

// File: doc/s4ga_ff.md
# s4ga_ff

Parametrised successor to the streaming LUT gate array. It accepts a serial stream of LUT configuration segments and evaluates one K-LUT per configuration. LUT outputs are held in an addressable array rather than a shift register, and index space also covers sampled primary inputs. Each LUT can be marked registered, so it updates only at frame boundaries. The stream can stall via a valid qualifier. The block sits between the tile's serial configuration pins and its user I/O.

## Interface
- N, 16: number of LUTs per frame (LUT numbers 0..N-1).
- K, 4: inputs per LUT.
- SI_W, 4: segment width; must be ≥1.
- N_IN, 4: primary inputs, addressed as indices N..N+N_IN-1.
- N_OUT, 8: LUT outputs exported on po; must be ≤N.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- si  in  SI_W  configuration segment.
- si_valid  in  1  segment accepted on an edge where high.
- pi  in  N_IN  primary inputs.
- po  out  N_OUT  value[N_OUT-1:0] (LUT n drives po[n]).
- frame_done  out  1  one-cycle pulse after LUT N-1 commits.

## Operation
- Derived widths:
  - IDX_W = clog2(N+N_IN).
  - IDX_SEGS = ceil(IDX_W/SI_W).
  - MASK_SEGS = ceil(2^K/SI_W).
  - Segments per LUT S = 1 + K·IDX_SEGS + MASK_SEGS (defaults: IDX_W=5, S=1+8+4=13).
- Per-LUT field order:
  - REG: 1 segment; bit 0 is the registered flag, other bits ignored.
  - IDX[0]..IDX[K-1]: IDX_SEGS segments each.
  - MASK: MASK_SEGS segments.
- Each field is its segments concatenated, most-significant segment first. Pad bits above IDX_W or 2^K are ignored.
- Index resolution, done on the edge accepting the last segment of IDX[i]; the result is stored as ins[i]:
  - index < N → value[index] (current value, so a self-reference reads the previous value).
  - N ≤ index < N+N_IN → pi_q[index-N].
  - index ≥ N+N_IN → 0.
- Commit, on the edge accepting the last MASK segment:
  - r = MASK[ins], where ins[i] is address bit i.
  - Combinational LUT (flag 0): value[n] ← r.
  - Registered LUT (flag 1): pending[n] ← r.
- Frame end, at commit of LUT N-1:
  - For every registered LUT j: value[j] ← pending[j], where LUT N-1 (if registered) uses r directly.
  - The LUT counter n wraps to 0.
- pi_q ← pi on the edge accepting the first segment (REG) of LUT 0. It is constant for the whole frame.
- FSM states: REG → IDX (k = 0..K-1, seg counter) → MASK (seg counter) → REG of the next LUT.
- si_valid = 0 holds all state: counters, shift register, flag and ins.
- Reset (also mid-LUT) clears value, pending, pi_q, ins, the flag, n, k, seg and frame_done, and discards any partial LUT. The next accepted segment is REG of LUT 0.

## Timing
- po is a direct view of value registers. A combinational LUT's new value appears on po the cycle after its commit edge.
- A registered LUT's new value appears on po the cycle after the commit edge of LUT N-1.
- frame_done is high for exactly the cycle following the LUT N-1 commit edge, even if si_valid is then low.
- A full frame with no stalls takes N·S accepted cycles; frame_done recurs every N·S cycles.
- Reset value of po and frame_done is 0.
- pi changes mid-frame are not visible until the next frame's LUT 0 REG edge.

## Test plan
- Reset: assert rst 2 cycles with garbage on si → po=0x00, frame_done=0. Then with si_valid=0 for 10 cycles → no change.
- Inverter (defaults): LUT0 comb, IDX all 16 (pi[0]), MASK 0x5555, pi=0x1. LUTs 1..15 are comb with MASK 0 → po[0]=0 after LUT0 commit, and po[0]=1 in a frame with pi=0x0.
- Registered toggle: LUT1 reg, IDX all 1, MASK 0x5555 → po[1] unchanged at LUT1 commit, then flips 0→1→0 on successive frame ends. frame_done pulses every 208 cycles.
- Stall: repeat the toggle stream with si_valid low on random 30% of cycles → identical po sequence per frame, and frame_done occurs after 208 accepted segments.
- Boundaries:
  - IDX=31 (out of range) with MASK 0xFFFE → LUT reads 0 and outputs 0.
  - rst mid-way through LUT 5's MASK segments, then a fresh stream → the first commit lands on LUT0.
- pi sampling: change pi[0] during LUT 3 of a frame → LUT0 inverter in the same frame keeps the old value and updates in the next frame.
